mux_bit_serializer: RTL

- Sequential front-end for the ALU's 32-to-1 bit-select mux.
- Captures a 32-bit word and drives it onto the mux data bus, then steps the mux select from 0 upward, one step per accepted bit.
- Forwards the mux result as a serial MSB-first bit stream under a valid/ready handshake.
- Mux contract: select 0 returns data bit 31 and select 31 returns data bit 0, so an ascending select yields MSB-first order.

---
 rtl/mux_bit_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux_bit_serializer.sv
// mux_bit_serializer: sequential front-end for the ALU's 32-to-1 bit-select mux.
// Captures a word onto the mux data bus, walks the select upward from 0 and
// forwards the mux output as an MSB-first serial stream under valid/ready.
// Select 0 returns data bit 31, so an ascending select yields MSB-first order.
module mux_bit_serializer #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              abort,
  output logic [DATA_W-1:0] mux_s,
  output logic [SEL_W-1:0]  mux_ctrl,
  input  logic              mux_result,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_data,
  output logic              bit_last,
  output logic              done,
  output logic              parity
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] mux_s_q,    mux_s_d;
  logic [SEL_W-1:0]  mux_ctrl_q, mux_ctrl_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic              parity_q,   parity_d;

  logic shift_w;
  logic last_w;
  logic accept_w;

  // Handshake qualifiers; len_q is never 0 while shifting, so len_q-1 is safe.
  always_comb begin
    shift_w  = (state_q == S_SHIFT);
    last_w   = shift_w && (LEN_W'(mux_ctrl_q) == (len_q - LEN_W'(1)));
    accept_w = shift_w && bit_ready;
  end

  // Next-state logic; abort overrides everything except reset.
  always_comb begin
    state_d    = state_q;
    mux_s_d    = mux_s_q;
    mux_ctrl_d = mux_ctrl_q;
    len_d      = len_q;
    parity_d   = parity_q;
    if (abort) begin
      // Flush to idle: parity and the captured word are kept for inspection.
      state_d    = S_IDLE;
      mux_ctrl_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            state_d    = S_SHIFT;
            mux_s_d    = load_data;
            mux_ctrl_d = '0;
            parity_d   = 1'b0;
            // A zero or oversized length means "send the whole word".
            if ((load_len == '0) || (load_len > FULL_LEN)) begin
              len_d = FULL_LEN;
            end else begin
              len_d = load_len;
            end
          end
        end
        S_SHIFT: begin
          if (accept_w) begin
            parity_d = parity_q ^ mux_result;
            // The select holds on the last bit so it never wraps past 31.
            if (last_w) begin
              state_d = S_DONE;
            end else begin
              mux_ctrl_d = mux_ctrl_q + SEL_W'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mux_s_q    <= '0;
      mux_ctrl_q <= '0;
      len_q      <= '0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mux_s_q    <= mux_s_d;
      mux_ctrl_q <= mux_ctrl_d;
      len_q      <= len_d;
      parity_q   <= parity_d;
    end
  end

  // Outputs decoded from registered state; bit_data is a straight pass-through.
  always_comb begin
    load_ready = (state_q == S_IDLE);
    bit_valid  = shift_w;
    bit_last   = last_w;
    bit_data   = mux_result;
    done       = (state_q == S_DONE);
    mux_s      = mux_s_q;
    mux_ctrl   = mux_ctrl_q;
    parity     = parity_q;
  end

endmodule
